dot_product_unit: RTL and testbench
===================================

DOT_PRODUCT_UNIT -- requirements
Module: dot_product_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the number of operand pairs per dot product (legal range 2..256).
REQ-002 SHALL have parameter BITS_AB, default 8, giving the signed width of each operand.
REQ-003 SHALL have parameter BITS_C, default 24, giving the signed accumulator and result width (BITS_C >= 2*BITS_AB).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a new dot product; honoured only in IDLE.
REQ-007 clr  input  1  synchronous abort; returns the block to IDLE.
REQ-008 ack  input  1  consumer has taken c_out; honoured only in DONE.
REQ-009 a_in  input  BITS_AB  signed operand A, taken directly from the upstream delay-buffer output.
REQ-010 b_in  input  BITS_AB  signed operand B, taken directly from the upstream delay-buffer output.
REQ-011 shift_en  output  1  shift enable driven to both upstream delay buffers.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 c_out  output  BITS_C  signed result; valid while done=1.
REQ-015 sat  output  1  sticky flag; at least one accumulation of the current job saturated.

Function
REQ-016 SHALL implement three states, IDLE, RUN and DONE, encoded in a single state register.
REQ-017 IDLE: start=1 and clr=0 -> RUN at the next edge; accumulator cleared to 0, sat cleared, element counter cleared to 0.
REQ-018 RUN: each cycle acc <= sat_add(acc, a_in*b_in) and count <= count+1; the product is full precision (2*BITS_AB) and sign-extended to BITS_C+1 before the add.
REQ-019 sat_add SHALL clamp to +(2^(BITS_C-1))-1 or -(2^(BITS_C-1)) on signed overflow and set sat, which stays 1 until the next accepted start or clr.
REQ-020 RUN -> DONE at the edge where count == DEPTH-1, i.e. after exactly DEPTH accumulations.
REQ-021 shift_en SHALL equal (state==RUN) combinationally; exactly DEPTH shift pulses per job; shift_en=0 in IDLE and DONE.
REQ-022 Latency: start sampled at edge k -> busy over cycles k+1..k+DEPTH -> done=1 from cycle k+DEPTH+1.
REQ-023 DONE: c_out and sat held stable; ack=1 -> IDLE at the next edge; without ack the block stays in DONE indefinitely.
REQ-024 c_out SHALL be the registered accumulator value; in IDLE it keeps the last result (0 after reset).
REQ-025 start in RUN or DONE SHALL be ignored with no queuing; ack outside DONE SHALL be ignored.
REQ-026 clr=1 in any state -> IDLE at the next edge, acc=0, count=0, sat=0; clr wins over simultaneous start or ack.
REQ-027 start and ack in the same cycle in DONE: ack takes effect and start is ignored, so a new job requires start while in IDLE.
REQ-028 The counter SHALL be ceil(log2(DEPTH)) bits wide and SHALL never wrap within a job.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, acc=0, count=0, c_out=0, sat=0, busy=0, done=0, shift_en=0, independent of clk.
REQ-030 Reset asserted mid-RUN SHALL abort the job with no further shift_en pulses; after release the block waits in IDLE for start.

Verification
REQ-031 DEPTH=8, a_in=1..8 and b_in=2 presented per shift -> 8 shift pulses, done at start+9 cycles, c_out=72, sat=0.
REQ-032 a_in=-128, b_in=-128 for all 8 elements with BITS_C=16 -> c_out=32767, sat=1.
REQ-033 clr pulsed on the 4th RUN cycle -> IDLE next cycle, shift_en=0, busy=0; a following start gives a correct fresh result.
REQ-034 start held high through RUN and DONE, ack after 5 DONE cycles -> single job, c_out stable for all 5 cycles, then IDLE, then a new job from the held start.
REQ-035 rst_n dropped asynchronously mid-RUN -> all outputs 0 before the next clk edge; after release start yields the correct sum.
REQ-036 Mixed signs a_in={3,-4,5,-6,7,-8,1,-2}, b_in=-1 -> c_out=4, sat=0.

Source files
------------

// File: rtl/dot_product_unit_if.sv
// dot_product_unit_if: operand, handshake and result signals of the dot product unit
interface dot_product_unit_if #(parameter int BITS_AB = 8, parameter int BITS_C = 24);
  logic start, clr, ack, shift_en, busy, done, sat;
  logic signed [BITS_AB-1:0] a_in, b_in;
  logic signed [BITS_C-1:0] c_out;
  modport master (output start, clr, ack, a_in, b_in, input shift_en, busy, done, c_out, sat);
  modport slave (input start, clr, ack, a_in, b_in, output shift_en, busy, done, c_out, sat);
endinterface

// File: rtl/dot_product_unit.sv
// dot_product_unit: saturating signed multiply-accumulate over DEPTH streamed operand pairs
module dot_product_unit #(
  parameter int DEPTH = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C = 24
) (
  input logic clk,
  input logic rst_n,
  dot_product_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH);
  localparam logic [BITS_C-1:0] MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] MIN = {1'b1, {(BITS_C-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic signed [BITS_C-1:0] acc, acc_nx;
  logic signed [2*BITS_AB-1:0] prod;
  logic [BITS_C:0] sum;
  logic sat_r, ovf, last, take;
  assign prod = bus.a_in * bus.b_in;
  assign sum = {acc[BITS_C-1], acc} + {{(BITS_C+1-2*BITS_AB){prod[2*BITS_AB-1]}}, prod};
  assign ovf = sum[BITS_C] != sum[BITS_C-1];
  assign acc_nx = ovf ? (sum[BITS_C] ? MIN : MAX) : sum[BITS_C-1:0];
  assign last = count == CW'(DEPTH-1);
  assign take = state == IDLE && bus.start;
  always_comb begin
    state_nx = bus.clr ? IDLE :
               take ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE && bus.ack) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      sat_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.clr || take) begin
        acc <= '0;
        count <= '0;
        sat_r <= 1'b0;
      end else if (state == RUN) begin
        acc <= acc_nx;
        count <= last ? count : count + 1'b1;
        sat_r <= sat_r | ovf;
      end
    end
  end
  assign bus.shift_en = state == RUN;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.c_out = acc;
  assign bus.sat = sat_r;
endmodule

// File: tb/tb_dot_product_unit.sv
// tb_dot_product_unit: table-driven and randomized checks of two dot product units (24- and 16-bit results)
module tb_dot_product_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dot_product_unit_if #(.BITS_AB(8), .BITS_C(24)) i24();
  dot_product_unit_if #(.BITS_AB(8), .BITS_C(16)) i16();
  dot_product_unit #(.DEPTH(8), .BITS_AB(8), .BITS_C(24)) dut24 (.clk(clk), .rst_n(rst_n), .bus(i24));
  dot_product_unit #(.DEPTH(8), .BITS_AB(8), .BITS_C(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));
  typedef logic [7:0][7:0] vec8_t;
  typedef struct {
    vec8_t a, b;
    longint c24;
    bit s24;
    longint c16;
    bit s16;
  } vec_t;
  int errors = 0, checks = 0;
  vec_t tbl[4];
  vec_t r;
  int mixed[8] = '{3, -4, 5, -6, 7, -8, 1, -2};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v); i24.start = v; i16.start = v; endtask
  task automatic set_clr(input logic v); i24.clr = v; i16.clr = v; endtask
  task automatic set_ack(input logic v); i24.ack = v; i16.ack = v; endtask
  task automatic ops(input logic [7:0] a, input logic [7:0] b);
    i24.a_in = a; i16.a_in = a; i24.b_in = b; i16.b_in = b;
  endtask
  task automatic step; @(posedge clk); #1; endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, i24.busy, 0);
    check({tag, "_done"}, i24.done, 0);
    check({tag, "_shift_en"}, i24.shift_en, 0);
    check({tag, "_c_out"}, i24.c_out, 0);
    check({tag, "_sat"}, i24.sat, 0);
    check({tag, "_c_out16"}, i16.c_out, 0);
    check({tag, "_sat16"}, i16.sat, 0);
  endtask

  // Saturating accumulation done step by step with wide integers
  function automatic longint ref_dot(input vec8_t a, input vec8_t b, input int bc, output bit s);
    longint acc = 0;
    longint hi = (longint'(1) <<< (bc - 1)) - 1;
    longint lo = -hi - 1;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      acc += longint'($signed(a[i])) * longint'($signed(b[i]));
      if (acc > hi) begin acc = hi; s = 1; end
      if (acc < lo) begin acc = lo; s = 1; end
    end
    return acc;
  endfunction

  task automatic start_job(input bit hold);
    set_start(1);
    set_ack($urandom_range(1));
    step;
    set_ack(0);
    if (!hold) set_start(0);
  endtask

  // Acts as the upstream delay buffers: a new element appears after each shift pulse
  task automatic feed_and_check(input vec_t v, input bit noise);
    int shifts = 0, cyc = 0;
    bit seen = 0;
    while (cyc < 20 && !seen) begin
      if (i24.shift_en) begin
        shifts++;
        if (shifts <= 8) ops(v.a[shifts-1], v.b[shifts-1]);
      end
      set_ack(noise ? 1'($urandom_range(1)) : 1'b0);
      step;
      cyc++;
      seen = i24.done;
    end
    set_ack(0);
    check("done_latency", cyc, 8);
    check("shift_count", shifts, 8);
    check("c_out24", i24.c_out, v.c24);
    check("sat24", i24.sat, v.s24);
    check("c_out16", i16.c_out, v.c16);
    check("sat16", i16.sat, v.s16);
    check("done16", i16.done, 1);
    check("done_busy", i24.busy, 0);
    check("done_shift_en", i24.shift_en, 0);
  endtask

  task automatic finish_job(input vec_t v);
    set_ack(1);
    step;
    set_ack(0);
    check("ack_done", i24.done, 0);
    check("ack_busy", i24.busy, 0);
    check("idle_c_out24", i24.c_out, v.c24);
    check("idle_c_out16", i16.c_out, v.c16);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[0].a[i] = 8'(i + 1); tbl[0].b[i] = 8'd2;
      tbl[1].a[i] = 8'h80; tbl[1].b[i] = 8'h80;
      tbl[2].a[i] = 8'(mixed[i]); tbl[2].b[i] = 8'hff;
      tbl[3].a[i] = 8'd127; tbl[3].b[i] = 8'h80;
    end
    tbl[0].c24 = 72; tbl[0].s24 = 0; tbl[0].c16 = 72; tbl[0].s16 = 0;
    tbl[1].c24 = 131072; tbl[1].s24 = 0; tbl[1].c16 = 32767; tbl[1].s16 = 1;
    tbl[2].c24 = 4; tbl[2].s24 = 0; tbl[2].c16 = 4; tbl[2].s16 = 0;
    tbl[3].c24 = -130048; tbl[3].s24 = 0; tbl[3].c16 = -32768; tbl[3].s16 = 1;
    set_start(0); set_clr(0); set_ack(0); ops(0, 0);
    #3 check_zero("reset");
    #10 rst_n = 1'b1;
    step;
    check_zero("post_reset");
    for (int t = 0; t < 4; t++) begin
      start_job(0);
      feed_and_check(tbl[t], 1);
      finish_job(tbl[t]);
    end
    set_start(1); set_clr(1);
    step;
    set_start(0); set_clr(0);
    check("clr_over_start_busy", i24.busy, 0);
    check("clr_over_start_shift", i24.shift_en, 0);
    start_job(0);
    feed_and_check(tbl[0], 0);
    set_clr(1); set_ack(1);
    step;
    set_clr(0); set_ack(0);
    check("clr_over_ack_done", i24.done, 0);
    check("clr_over_ack_c_out", i24.c_out, 0);
    start_job(0);
    for (int i = 0; i < 4; i++) begin
      ops(tbl[1].a[i], tbl[1].b[i]);
      if (i == 3) set_clr(1);
      step;
    end
    set_clr(0);
    check_zero("clr_mid_run");
    start_job(0);
    feed_and_check(tbl[2], 1);
    finish_job(tbl[2]);
    start_job(1);
    feed_and_check(tbl[0], 0);
    for (int i = 0; i < 5; i++) begin
      step;
      check("held_done", i24.done, 1);
      check("held_c_out", i24.c_out, 72);
    end
    set_ack(1);
    step;
    set_ack(0);
    check("held_ack_done", i24.done, 0);
    check("held_ack_busy", i24.busy, 0);
    step;
    check("held_restart_busy", i24.busy, 1);
    set_start(0);
    feed_and_check(tbl[2], 0);
    finish_job(tbl[2]);
    start_job(0);
    for (int i = 0; i < 3; i++) begin
      ops(tbl[3].a[i], tbl[3].b[i]);
      step;
    end
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    step;
    step;
    #2 rst_n = 1'b1;
    step;
    check("post_abort_shift", i24.shift_en, 0);
    check("post_abort_busy", i24.busy, 0);
    start_job(0);
    feed_and_check(tbl[0], 1);
    finish_job(tbl[0]);
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 8; i++) begin
        r.a[i] = ($urandom_range(3) == 0) ? 8'h80 : 8'($urandom);
        r.b[i] = ($urandom_range(3) == 0) ? 8'(n[0] ? 8'h80 : 8'h7f) : 8'($urandom);
      end
      r.c24 = ref_dot(r.a, r.b, 24, r.s24);
      r.c16 = ref_dot(r.a, r.b, 16, r.s16);
      start_job(0);
      feed_and_check(r, 1);
      finish_job(r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
